// File: rtl/uart_seq_pkg.sv
// Shared definitions for the UART command sequencer: FSM encoding and
// command packet field positions.
package uart_seq_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT_RD = 2'd2
    } seq_state_e;

    localparam int CMD_RW_BIT   = 15;
    localparam int CMD_ADDR_LSB = 8;
    localparam int CMD_DATA_LSB = 0;

    localparam logic CMD_WRITE = 1'b1;

endpackage

// File: rtl/uart_cmd_fifo.sv
// Synchronous request FIFO; pointers carry an extra MSB so full and empty
// are distinguishable without a separate occupancy counter.
module uart_cmd_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/uart_cmd_sequencer.sv
// Queues host register requests, issues them one at a time as UART command
// packets and returns a single response (data or timeout) for each read.
module uart_cmd_sequencer
    import uart_seq_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 7,
    parameter int CMD_PKT_LEN    = 16,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 50_000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_write,
    input  logic [ADDR_WIDTH-1:0]  req_addr,
    input  logic [DATA_WIDTH-1:0]  req_wdata,
    output logic [CMD_PKT_LEN-1:0] cmd,
    output logic                   uart_valid,
    input  logic                   uart_ready,
    input  logic [DATA_WIDTH-1:0]  read_data,
    input  logic                   read_valid,
    output logic                   rsp_valid,
    output logic [DATA_WIDTH-1:0]  rsp_rdata,
    output logic                   rsp_timeout,
    output logic [7:0]             stray_count,
    output logic                   busy
);

    localparam int ENTRY_W = 1 + ADDR_WIDTH + DATA_WIDTH;
    localparam int CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    seq_state_e             state_q, state_d;
    logic [CMD_PKT_LEN-1:0] cmd_q, cmd_d;
    logic                   uart_valid_q;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]  rsp_rdata_q, rsp_rdata_d;
    logic                   rsp_timeout_q, rsp_timeout_d;
    logic [7:0]             stray_q, stray_d;

    logic                   fifo_push;
    logic                   fifo_pop;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [ENTRY_W-1:0]     fifo_din;
    logic [ENTRY_W-1:0]     fifo_dout;
    logic                   head_write;
    logic [ADDR_WIDTH-1:0]  head_addr;
    logic [DATA_WIDTH-1:0]  head_wdata;

    assign req_ready = !fifo_full;
    assign fifo_push = req_valid && !fifo_full;
    assign fifo_din  = {req_write, req_addr, req_wdata};
    assign {head_write, head_addr, head_wdata} = fifo_dout;

    uart_cmd_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_d       = state_q;
        cmd_d         = cmd_q;
        cnt_d         = cnt_q;
        rsp_valid_d   = 1'b0;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_timeout_d = rsp_timeout_q;
        fifo_pop      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop                              = 1'b1;
                    cmd_d                                 = '0;
                    cmd_d[CMD_RW_BIT]                     = head_write;
                    cmd_d[CMD_ADDR_LSB +: ADDR_WIDTH]     = head_addr;
                    // Reads carry a zero data field regardless of what the host drove.
                    if (head_write == CMD_WRITE)
                        cmd_d[CMD_DATA_LSB +: DATA_WIDTH] = head_wdata;
                    state_d                               = ISSUE;
                end
            end
            ISSUE: begin
                if (uart_ready) begin
                    if (cmd_q[CMD_RW_BIT] == CMD_WRITE) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d   = '0;
                        state_d = WAIT_RD;
                    end
                end
            end
            WAIT_RD: begin
                cnt_d = cnt_q + CNT_W'(1);
                // A data byte arriving on the final cycle beats the timeout.
                if (read_valid) begin
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = read_data;
                    rsp_timeout_d = 1'b0;
                    state_d       = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = '0;
                    rsp_timeout_d = 1'b1;
                    state_d       = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        stray_d = stray_q;
        if (read_valid && (state_q != WAIT_RD) && (stray_q != 8'hFF))
            stray_d = stray_q + 8'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            cmd_q         <= '0;
            uart_valid_q  <= 1'b0;
            cnt_q         <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_timeout_q <= 1'b0;
            stray_q       <= '0;
        end else begin
            state_q       <= state_d;
            cmd_q         <= cmd_d;
            uart_valid_q  <= (state_d == ISSUE);
            cnt_q         <= cnt_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_timeout_q <= rsp_timeout_d;
            stray_q       <= stray_d;
        end
    end

    assign cmd         = cmd_q;
    assign uart_valid  = uart_valid_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_timeout = rsp_timeout_q;
    assign stray_count = stray_q;
    assign busy        = !fifo_empty || (state_q != IDLE);

endmodule

// File: doc/uart_cmd_sequencer.md
# uart_cmd_sequencer

Host-side command sequencer that sits directly upstream of the UART top-level block. It queues register read/write requests from a host, packs each into the 16-bit UART command packet, and issues packets with a valid/ready handshake. For each read it waits for the returned byte, with a timeout, and delivers a single response to the host.

## Interface
Parameters:
- DATA_WIDTH, 8, data byte width
- ADDR_WIDTH, 7, register address width
- CMD_PKT_LEN, 16, command packet width; equals 1 + ADDR_WIDTH + DATA_WIDTH
- FIFO_DEPTH, 4, request queue entries; power of two, ≥ 2
- TIMEOUT_CYCLES, 50_000, clk cycles to wait for read data (1 ms at 50 MHz)

Ports:
- clk  in  1  system clock, 50 MHz
- rst  in  1  reset; one clock; reset is asynchronous and active-high
- req_valid  in  1  host request valid
- req_ready  out  1  request accepted when high with req_valid; equals !fifo_full
- req_write  in  1  1 = write, 0 = read
- req_addr  in  ADDR_WIDTH  register address
- req_wdata  in  DATA_WIDTH  write data; ignored for reads
- cmd  out  CMD_PKT_LEN  [15] R/W (1 = write), [14:8] address, [7:0] data (0 for reads)
- uart_valid  out  1  cmd valid toward UART
- uart_ready  in  1  UART accepts cmd
- read_data  in  DATA_WIDTH  byte returned by UART
- read_valid  in  1  read_data valid, 1-cycle pulse
- rsp_valid  out  1  1-cycle read response pulse
- rsp_rdata  out  DATA_WIDTH  read data; 0 on timeout
- rsp_timeout  out  1  qualifies rsp_valid: read timed out
- stray_count  out  8  saturating count of read_valid pulses received outside WAIT_RD
- busy  out  1  FIFO not empty, or state ≠ IDLE

## Operation
- **Queue.** FIFO of {write, addr, wdata}. Push on req_valid && req_ready. When full, req_ready stays 0 even in a pop cycle. Occupancy wraps via pointers with an extra MSB.
- **FSM states: IDLE, ISSUE, WAIT_RD.**
- IDLE: if the FIFO is non-empty, pop the head into the cmd register and go to ISSUE. Otherwise stay.
- ISSUE: uart_valid = 1; cmd is held stable until the handshake.
  - On uart_valid && uart_ready: a write goes to IDLE with no response; a read clears the timeout counter and goes to WAIT_RD.
- WAIT_RD: the counter increments each cycle.
  - If read_valid: register rsp_rdata = read_data, rsp_timeout = 0, pulse rsp_valid, go to IDLE.
  - Else if counter == TIMEOUT_CYCLES-1: rsp_rdata = 0, rsp_timeout = 1, pulse rsp_valid, go to IDLE.
  - If read_valid and the timeout coincide, read_valid wins.
- read_valid in IDLE or ISSUE is dropped and increments stray_count, which saturates at 255.
- Requests are issued strictly in order; only one command is outstanding.
- Reset mid-operation abandons the in-flight command and all queued entries. No response is generated.

## Timing
- Reset values:
  - req_ready = 1 (FIFO empty)
  - cmd = 0, uart_valid = 0
  - rsp_valid = 0, rsp_rdata = 0, rsp_timeout = 0
  - stray_count = 0, busy = 0
- Push at edge N into an empty FIFO in IDLE → busy at N+1 → pop at N+1 → uart_valid = 1 and cmd valid from N+2.
- uart_valid drops the cycle after the handshake edge.
- Back-to-back writes with uart_ready tied high: one command every 2 cycles.
- read_valid sampled at edge M → rsp_valid high for cycle M+1 only.
- Timeout: rsp_valid asserts exactly TIMEOUT_CYCLES cycles after the read handshake edge.
- All outputs are registered except req_ready and busy, which are combinational from registers.

## Structure
- Shared package uart_seq_pkg holds:
  - state encoding (IDLE = 0, ISSUE = 1, WAIT_RD = 2)
  - CMD_RW_BIT = 15, CMD_ADDR_LSB = 8, CMD_DATA_LSB = 0
  - CMD_WRITE = 1'b1
- One sub-module: uart_cmd_fifo, a synchronous FIFO with async active-high reset.
  - Parameters: WIDTH, DEPTH.
  - Ports: push, pop, din, dout, full, empty.
- The FSM, timeout counter and stray counter live in uart_cmd_sequencer.

## Test plan
- Single write: req write addr 0x12 data 0xA5, uart_ready = 1 → cmd = 0x92A5 with uart_valid for 1 cycle; no rsp_valid; busy returns to 0.
- Read success: req read addr 0x05; read_valid with 0x3C 10 cycles after the handshake → cmd = 0x0500; rsp_valid for 1 cycle with rsp_rdata = 0x3C, rsp_timeout = 0.
- Read timeout (TIMEOUT_CYCLES = 20): read addr 0x7F, no read_valid → cmd = 0x7F00; rsp_valid 20 cycles after the handshake with rsp_timeout = 1, rsp_rdata = 0. A coincident read_valid on cycle 20 instead yields rsp_timeout = 0.
- Backpressure and full: uart_ready = 0, push 5 writes → the first is latched into cmd, the FIFO holds 4, then req_ready = 0. Release uart_ready → all 5 are issued in order and cmd stays stable while stalled.
- Stray data: 3 read_valid pulses in IDLE → stray_count = 3, no rsp_valid.
- Reset in WAIT_RD: assert rst → all outputs at their reset values immediately; after release, a late read_valid increments stray_count to 1.
